tx_gearbox: RTL and testbench

- 66:64 TX gearbox, directly downstream of the PCS scrambler.
- Packs a 2-bit sync header plus two 32-bit scrambled halves per 66-bit block into a continuous 32-bit PMA word stream.
- Inserts one input stall (o_tx_pause) every 33 cycles. Upstream encoder and scrambler hold state during the stall, which absorbs the 2-bit-per-block header overhead.

---
 rtl/tx_gearbox_if.sv | 32 +++
 rtl/tx_gearbox.sv | 89 ++++++++
 tb/tb_tx_gearbox.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tx_gearbox_if.sv
// Bus bundle between the PCS scrambler/encoder side and the 66:64 TX gearbox.
// TX_GEARBOX_HDR_CHECK_EN adds the o_header_err flag.
interface tx_gearbox_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 6
);
    logic [DATA_WIDTH-1:0] i_txd;
    logic [1:0]            i_tx_header;
    logic [DATA_WIDTH-1:0] o_txd;
    logic                  o_tx_pause;
    logic                  o_tx_first_half;
    logic [SEQ_WIDTH-1:0]  o_seq;
`ifdef TX_GEARBOX_HDR_CHECK_EN
    logic                  o_header_err;
`endif

    modport master (
        output i_txd, i_tx_header,
`ifdef TX_GEARBOX_HDR_CHECK_EN
        input  o_header_err,
`endif
        input  o_txd, o_tx_pause, o_tx_first_half, o_seq
    );

    modport slave (
        input  i_txd, i_tx_header,
`ifdef TX_GEARBOX_HDR_CHECK_EN
        output o_header_err,
`endif
        output o_txd, o_tx_pause, o_tx_first_half, o_seq
    );
endinterface

// File: rtl/tx_gearbox.sv
// 66:64 TX gearbox: packs header + two 32-bit halves per block into a 32-bit PMA stream,
// stalling the input once every 33 cycles. Optional TX_GEARBOX_HDR_CHECK_EN flags bad headers.
module tx_gearbox #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 6
) (
    input  logic           i_txc,
    input  logic           i_reset_n,
    tx_gearbox_if.slave    bus
);
    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("tx_gearbox: only DATA_WIDTH=32 is supported");
        end
        if (SEQ_WIDTH < 6) begin : g_bad_seq
            $error("tx_gearbox: SEQ_WIDTH must hold 0..32");
        end
    endgenerate

    localparam logic [SEQ_WIDTH-1:0] SEQ_LAST = SEQ_WIDTH'(32);

    logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
    logic [5:0]              fill_q, fill_d;
    logic [63:0]             resid_q, resid_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;
    logic                    pause;
    logic                    first_half;
    logic [DATA_WIDTH+1:0]   append;
    logic [3*DATA_WIDTH-1:0] comb;

    always_comb begin
        pause      = (seq_q == SEQ_LAST);
        first_half = (seq_q < SEQ_LAST) && !seq_q[0];

        append = '0;
        if (first_half) begin
            append = {bus.i_txd, bus.i_tx_header};
        end else if (!pause) begin
            append = {2'b00, bus.i_txd};
        end

        // Residual sits in the low bits; new bits land just above the current fill.
        comb    = {32'b0, resid_q} | ({62'b0, append} << fill_q);
        txd_d   = comb[DATA_WIDTH-1:0];
        resid_d = comb[3*DATA_WIDTH-1:DATA_WIDTH];

        fill_d = fill_q;
        if (pause) begin
            fill_d = '0;
        end else if (first_half) begin
            fill_d = fill_q + 6'd2;
        end

        seq_d = pause ? '0 : seq_q + SEQ_WIDTH'(1);
    end

    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq_q   <= '0;
            fill_q  <= '0;
            resid_q <= '0;
            txd_q   <= '0;
        end else begin
            seq_q   <= seq_d;
            fill_q  <= fill_d;
            resid_q <= resid_d;
            txd_q   <= txd_d;
        end
    end

    assign bus.o_txd           = txd_q;
    assign bus.o_tx_pause      = pause;
    assign bus.o_tx_first_half = first_half;
    assign bus.o_seq           = seq_q;

`ifdef TX_GEARBOX_HDR_CHECK_EN
    logic hdr_err_q;

    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hdr_err_q <= 1'b0;
        end else begin
            hdr_err_q <= first_half && (bus.i_tx_header[0] == bus.i_tx_header[1]);
        end
    end

    assign bus.o_header_err = hdr_err_q;
`endif
endmodule

// File: tb/tb_tx_gearbox.sv
// Self-checking bench for tx_gearbox: vector table, hand sequences and a bit-serial scoreboard.
module tb_tx_gearbox;
    localparam int DW = 32;
    localparam int SW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tx_gearbox_if #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW)) bus ();

    tx_gearbox #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW)) dut (
        .i_txc     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  h;
        logic [31:0] txd;
        int          seq;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit          bq[$];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One input cycle: check seq-derived outputs, drive inputs, model the bit stream,
    // then compare the registered word after the edge.
    task automatic step(input logic [31:0] d, input logic [1:0] h);
        int          s;
        logic [31:0] w;
        logic        exp_err;
        s = cyc % 33;
        check("seq", 64'(bus.o_seq), 64'(s));
        check("pause", 64'(bus.o_tx_pause), 64'(s == 32));
        check("first_half", 64'(bus.o_tx_first_half), 64'(s < 32 && (s % 2) == 0));
        bus.i_txd       = d;
        bus.i_tx_header = h;
        if (s < 32) begin
            if ((s % 2) == 0) begin
                bq.push_back(h[0]);
                bq.push_back(h[1]);
            end
            for (int i = 0; i < 32; i++) bq.push_back(d[i]);
        end
        w = '0;
        if (bq.size() < 32) begin
            errors++;
            $display("FAIL model_underflow: got %0d bits expected 32", bq.size());
        end else begin
            for (int i = 0; i < 32; i++) w[i] = bq.pop_front();
        end
        exp_q.push_back(w);
        exp_err = (s < 32) && ((s % 2) == 0) && (h == 2'b00 || h == 2'b11);
        @(posedge clk);
        #1;
        check("txd", 64'(bus.o_txd), 64'(exp_q.pop_front()));
`ifdef TX_GEARBOX_HDR_CHECK_EN
        check("header_err", 64'(bus.o_header_err), 64'(exp_err));
`else
        if (exp_err) begin end
`endif
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_txd", 64'(bus.o_txd), 64'd0);
        check("rst_seq", 64'(bus.o_seq), 64'd0);
        check("rst_pause", 64'(bus.o_tx_pause), 64'd0);
        check("rst_first_half", 64'(bus.o_tx_first_half), 64'd1);
`ifdef TX_GEARBOX_HDR_CHECK_EN
        check("rst_header_err", 64'(bus.o_header_err), 64'd0);
`endif
        bq.delete();
        exp_q.delete();
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[4];

    initial begin
        logic [31:0] d0;
        logic [1:0]  h0;
        logic [31:0] want;

        tbl[0] = '{d: 32'hFFFF_FFFF, h: 2'b10, txd: 32'hFFFF_FFFE, seq: 0};
        tbl[1] = '{d: 32'h0000_0000, h: 2'b11, txd: 32'h0000_0003, seq: 1};
        tbl[2] = '{d: 32'h1234_5678, h: 2'b01, txd: 32'h2345_6784, seq: 2};
        tbl[3] = '{d: 32'hAAAA_AAAA, h: 2'b00, txd: 32'hAAAA_AAA1, seq: 3};

        rst_n           = 1'b0;
        bus.i_txd       = '0;
        bus.i_tx_header = 2'b01;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            check("tbl_seq", 64'(bus.o_seq), 64'(tbl[i].seq));
            step(tbl[i].d, tbl[i].h);
            check("tbl_txd", 64'(bus.o_txd), 64'(tbl[i].txd));
        end

        // Pause cadence: pause expected at cycles 32, 65, 98.
        while (cyc < 100) step(32'h0, 2'b01);

        // Pause integrity: junk on the stall cycle must never reach the stream.
        do_reset();
        while (cyc < 32) step($urandom, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
        check("pause_flag", 64'(bus.o_tx_pause), 64'd1);
        step(32'hDEAD_BEEF, 2'b11);
        for (int i = 0; i < 40; i++) step($urandom, 2'b01);

        // Mid-frame reset at seq 17, then restart with a fresh first half.
        do_reset();
        while (cyc < 17) step($urandom | 32'h1, 2'b10);
        check("pre_reset_seq", 64'(bus.o_seq), 64'd17);
        rst_n = 1'b0;
        #1;
        check("async_txd", 64'(bus.o_txd), 64'd0);
        check("async_seq", 64'(bus.o_seq), 64'd0);
        do_reset();
        d0 = $urandom;
        h0 = 2'b10;
        want = {d0[29:0], h0};
        step(d0, h0);
        check("restart_word", 64'(bus.o_txd), 64'(want));
        for (int i = 0; i < 10; i++) step($urandom, 2'b01);

`ifdef TX_GEARBOX_HDR_CHECK_EN
        do_reset();
        while (cyc < 4) step($urandom, 2'b01);
        step($urandom, 2'b11);
        check("hdr_pulse", 64'(bus.o_header_err), 64'd1);
        step($urandom, 2'b00);
        check("hdr_odd_quiet", 64'(bus.o_header_err), 64'd0);
        step($urandom, 2'b01);
        check("hdr_after", 64'(bus.o_header_err), 64'd0);
`endif

        // Long run: 6600 cycles of random data with valid headers.
        do_reset();
        for (int i = 0; i < 6600; i++) step($urandom, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
